// File: rtl/timer_irq_peripheral.sv
// Memory-mapped timer and interrupt source for the single-cycle MIPS core.
//
// This block raises IRQ. The Control unit consumes it by diverting the PC to
// the handler and linking into $k0. The CPU data-memory bus programs the
// timer through MemWr/MemRd and a byte address. The timer also provides a
// free-running systick counter.
//
// Register window (word offsets from BASE_ADDR):
//   +0x0 TH      reload value, R/W
//   +0x4 TL      count, R/W
//   +0x8 TCON    [0]=run [1]=irq_en [2]=irq_status, R/W; [31:3] read 0
//   +0xC SYSTICK free-running cycle counter, read-only
//
// Ports:
//   clk       system clock, posedge
//   reset     asynchronous active-high reset
//   MemRd     bus read strobe (no side effects)
//   MemWr     bus write strobe, sampled at posedge clk
//   Addr      byte address; bits [1:0] ignored
//   WriteData bus write data
//   ReadData  read data, combinational from Addr/MemRd
//   kernel    CPU in kernel mode; masks IRQ
//   IRQ       level interrupt request to Control
module timer_irq_peripheral #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  input  logic        kernel,
  output logic        IRQ
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PRESCALE - 1);

  logic [31:0]     th_q, tl_q, systick_q;
  logic [CntW-1:0] cnt_q;
  logic            run_q, irq_en_q, irq_status_q;

  // Byte-lane bits are ignored by the decoder.
  logic [1:0] unused_addr_lsb;
  assign unused_addr_lsb = Addr[1:0];

  // Decode on word address; the subtraction also keeps the window correct
  // for a BASE_ADDR that is not 16-byte aligned.
  logic [29:0] word_off;
  logic        in_win;
  logic [1:0]  idx;
  assign word_off = Addr[31:2] - BASE_ADDR[31:2];
  assign in_win   = (word_off < 30'd4);
  assign idx      = word_off[1:0];

  logic wr_th, wr_tl, wr_tcon;
  assign wr_th   = MemWr & in_win & (idx == 2'd0);
  assign wr_tl   = MemWr & in_win & (idx == 2'd1);
  assign wr_tcon = MemWr & in_win & (idx == 2'd2);

  logic tick, overflow, status_set;
  assign tick       = run_q & (cnt_q == CntLast);
  assign overflow   = tick & (tl_q == 32'hFFFF_FFFF);
  // A CPU write to TL on the same edge suppresses both reload and status.
  assign status_set = overflow & irq_en_q & ~wr_tl;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q         <= '0;
      tl_q         <= '0;
      systick_q    <= '0;
      cnt_q        <= '0;
      run_q        <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_status_q <= 1'b0;
    end else begin
      systick_q <= systick_q + 32'd1;

      if (run_q) begin
        cnt_q <= tick ? '0 : cnt_q + CntW'(1);
      end

      if (wr_th) begin
        th_q <= WriteData;
      end

      // Reload uses the TH value from before any same-edge TH write.
      if (wr_tl) begin
        tl_q <= WriteData;
      end else if (tick) begin
        tl_q <= overflow ? th_q : tl_q + 32'd1;
      end

      if (wr_tcon) begin
        run_q    <= WriteData[0];
        irq_en_q <= WriteData[1];
      end

      // Hardware set beats a software clear on the same edge.
      irq_status_q <= status_set | (wr_tcon ? WriteData[2] : irq_status_q);
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRd && in_win) begin
      case (idx)
        2'd0:    ReadData = th_q;
        2'd1:    ReadData = tl_q;
        2'd2:    ReadData = {29'd0, irq_status_q, irq_en_q, run_q};
        default: ReadData = systick_q;
      endcase
    end
  end

  assign IRQ = irq_status_q & irq_en_q & ~kernel;

endmodule

// File: tb/tb_timer_irq_peripheral.sv
module tb_timer_irq_peripheral;

  localparam logic [31:0] Base  = 32'h4000_0000;
  localparam logic [31:0] ATh   = Base + 32'h0;
  localparam logic [31:0] ATl   = Base + 32'h4;
  localparam logic [31:0] ATcon = Base + 32'h8;
  localparam logic [31:0] ATick = Base + 32'hC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] WriteData = '0;
  logic        kernel = 1'b0;
  logic [31:0] rdata1, rdata4;
  logic        irq1, irq4;

  always #5 clk = ~clk;

  timer_irq_peripheral #(.BASE_ADDR(Base), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
    .WriteData(WriteData), .ReadData(rdata1), .kernel(kernel), .IRQ(irq1)
  );

  timer_irq_peripheral #(.BASE_ADDR(Base), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
    .WriteData(WriteData), .ReadData(rdata4), .kernel(kernel), .IRQ(irq4)
  );

  // Cycle model for systick: edges seen since reset was last released.
  logic [31:0] cyc;
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= '0;
    else       cyc <= cyc + 32'd1;
  end

  typedef struct {
    bit          which4;
    logic [31:0] exp_rd;
    bit          chk_irq;
    logic        exp_irq;
    string       name;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // Monitor: every read the bus presents is matched against the queue.
  always @(negedge clk) begin
    if (MemRd) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL scoreboard_underflow: got read with Addr=%h, expected none", Addr);
      end else begin
        exp_t e;
        logic [31:0] act;
        logic        act_irq;
        e = q.pop_front();
        act     = e.which4 ? rdata4 : rdata1;
        act_irq = e.which4 ? irq4 : irq1;
        if (act !== e.exp_rd) begin
          fails++;
          $display("FAIL %s: ReadData=%h expected %h", e.name, act, e.exp_rd);
        end
        if (e.chk_irq) begin
          tests++;
          if (act_irq !== e.exp_irq) begin
            fails++;
            $display("FAIL %s_irq: IRQ=%b expected %b", e.name, act_irq, e.exp_irq);
          end
        end
      end
    end
  end

  task automatic push(input bit w4, input logic [31:0] a, input logic [31:0] exp,
                      input bit ci, input logic ei, input string nm);
    exp_t e;
    e.which4 = w4; e.exp_rd = exp; e.chk_irq = ci; e.exp_irq = ei; e.name = nm;
    q.push_back(e);
    Addr  = a;
    MemRd = 1'b1;
  endtask

  task automatic rd(input bit w4, input logic [31:0] a, input logic [31:0] exp,
                    input bit ci, input logic ei, input string nm);
    push(w4, a, exp, ci, ei, nm);
    @(posedge clk); #1;
    MemRd = 1'b0;
  endtask

  // Read while reset is held high, before any clock edge can occur.
  task automatic rd_rst(input bit w4, input logic [31:0] a, input string nm);
    reset = 1'b1;
    push(w4, a, 32'h0, 1'b1, 1'b0, nm);
    @(posedge clk); #1;
    MemRd = 1'b0;
    reset = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a; WriteData = d; MemWr = 1'b1;
    @(posedge clk); #1;
    MemWr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state and systick progression.
    rd(0, ATh,   32'h0, 1, 0, "rst_th");
    rd(0, ATl,   32'h0, 1, 0, "rst_tl");
    rd(0, ATcon, 32'h0, 1, 0, "rst_tcon");
    rd(0, ATick, cyc, 0, 0, "systick0");
    rd(0, ATick, cyc, 0, 0, "systick1");
    rd(0, ATick, cyc, 0, 0, "systick2");

    // Overflow with reload and interrupt.
    wr(ATh, 32'hFFFF_FFF0);
    wr(ATl, 32'hFFFF_FFFE);
    wr(ATcon, 32'd3);
    rd(0, ATl,   32'hFFFF_FFFE, 1, 0, "ovf_tl_fffe");
    rd(0, ATl,   32'hFFFF_FFFF, 1, 0, "ovf_tl_ffff");
    rd(0, ATl,   32'hFFFF_FFF0, 1, 1, "ovf_reload");
    rd(0, ATcon, 32'd7,         1, 1, "ovf_tcon7");

    // Kernel masking and software clear.
    kernel = 1'b1;
    rd(0, ATcon, 32'd7, 1, 0, "kernel_mask");
    wr(ATcon, 32'd3);
    kernel = 1'b0;
    rd(0, ATcon, 32'd3, 1, 0, "sw_clear");
    wr(ATcon, 32'd0);

    // TL write on an overflowing tick: write wins, no status.
    wr(ATh, 32'h200);
    wr(ATl, 32'hFFFF_FFFF);
    wr(ATcon, 32'd3);
    wr(ATl, 32'd5);
    rd(0, ATl,   32'd5, 1, 0, "tlwr_vs_tick");
    rd(0, ATcon, 32'd3, 1, 0, "tlwr_no_status");
    wr(ATcon, 32'd0);

    // TH write on reload edge: TL gets old TH.
    wr(ATh, 32'h300);
    wr(ATl, 32'hFFFF_FFFE);
    wr(ATcon, 32'd1);
    idle(1);
    wr(ATh, 32'h400);
    rd(0, ATl, 32'h300, 0, 0, "reload_old_th");
    rd(0, ATh, 32'h400, 0, 0, "th_new");
    wr(ATcon, 32'd0);

    // run=0 written on a tick edge: that tick still counts.
    wr(ATl, 32'd10);
    wr(ATcon, 32'd1);
    wr(ATcon, 32'd0);
    rd(0, ATl, 32'd11, 0, 0, "stop_tick_applies");
    rd(0, ATl, 32'd11, 0, 0, "stopped_holds");

    // Overflow coincides with TCON=3 write: set wins.
    wr(ATh, 32'h100);
    wr(ATl, 32'hFFFF_FFFE);
    wr(ATcon, 32'd3);
    idle(1);
    wr(ATcon, 32'd3);
    rd(0, ATl,   32'h100, 1, 1, "set_wins_tl");
    rd(0, ATcon, 32'd7,   1, 1, "set_wins_tcon");

    // Async reset with IRQ high: clears without a clock edge.
    rd_rst(0, ATcon, "async_rst_irq");
    rd(0, ATh, 32'h0, 1, 0, "post_rst_th");
    rd(0, ATl, 32'h0, 1, 0, "post_rst_tl");

    // Out-of-window writes and reads.
    wr(ATh, 32'h55);
    wr(Base + 32'h10, 32'hFFFF_FFFF);
    wr(32'h0000_0010, 32'h1234);
    wr(ATick, 32'hDEAD);
    rd(0, ATh,            32'h55, 0, 0, "oow_th");
    rd(0, ATl,            32'h0,  0, 0, "oow_tl");
    rd(0, ATcon,          32'h0,  0, 0, "oow_tcon");
    rd(0, Base + 32'h10,  32'h0,  0, 0, "oow_read");
    rd(0, 32'h0,          32'h0,  0, 0, "oow_read_zero");
    rd(0, Base + 32'h1,   32'h55, 0, 0, "unaligned_th");
    rd(0, Base + 32'hE,   cyc,    0, 0, "systick_ro");

    // Prescaler of 4.
    pulse_reset();
    wr(ATcon, 32'd1);
    idle(3);
    rd(1, ATl, 32'd0, 0, 0, "ps4_clk3");
    rd(1, ATl, 32'd1, 0, 0, "ps4_clk4");
    idle(2);
    rd(1, ATl, 32'd1, 0, 0, "ps4_clk7");
    rd(1, ATl, 32'd2, 0, 0, "ps4_clk8");

    pulse_reset();
    wr(ATcon, 32'd1);
    idle(3);
    rd(1, ATl, 32'd0, 0, 0, "ps4b_clk3");
    rd(1, ATl, 32'd1, 0, 0, "ps4b_clk4");
    rd_rst(1, ATl, "ps4_async_rst");

    idle(2);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
